bus_bridge: RTL and testbench

BUS_BRIDGE -- requirements
Module: bus_bridge

---
 rtl/bus_bridge_pkg.sv | 49 ++++
 rtl/bus_bridge_seg_scan.sv | 50 +++++
 rtl/bus_bridge.sv | 100 ++++++++++
 tb/tb_bus_bridge.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_bridge_pkg.sv
// Shared constants for the CPU-to-peripheral bus bridge: address map,
// transfer codes, scan-rate default and the 7-segment pattern table.
package bus_bridge_pkg;

    // Transfer codes on en_data_trans; 2'b11 is reserved and behaves as idle.
    typedef enum logic [1:0] {
        TRANS_IDLE  = 2'b00,
        TRANS_READ  = 2'b01,
        TRANS_WRITE = 2'b10
    } trans_e;

    // Upper 20 address bits selecting the peripheral page.
    localparam logic [19:0] PERIPH_PAGE = 20'hFFFFF;

    // Peripheral register addresses.
    localparam logic [31:0] ADDR_DIG   = 32'hFFFF_F000;
    localparam logic [31:0] ADDR_TIMER = 32'hFFFF_F020;
    localparam logic [31:0] ADDR_LED   = 32'hFFFF_F060;
    localparam logic [31:0] ADDR_SW    = 32'hFFFF_F070;
    localparam logic [31:0] ADDR_BTN   = 32'hFFFF_F078;

    // Default cpu_clk cycles spent on each 7-segment digit.
    localparam int unsigned SCAN_DIV_DEFAULT = 20000;

    // Active-low {dp,g,f,e,d,c,b,a} hex pattern, decimal point off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] hex);
        logic [7:0] pat;
        case (hex)
            4'h0:    pat = 8'hC0;
            4'h1:    pat = 8'hF9;
            4'h2:    pat = 8'hA4;
            4'h3:    pat = 8'hB0;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h92;
            4'h6:    pat = 8'h82;
            4'h7:    pat = 8'hF8;
            4'h8:    pat = 8'h80;
            4'h9:    pat = 8'h90;
            4'hA:    pat = 8'h88;
            4'hB:    pat = 8'h83;
            4'hC:    pat = 8'hC6;
            4'hD:    pat = 8'hA1;
            4'hE:    pat = 8'h86;
            default: pat = 8'h8E;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/bus_bridge_seg_scan.sv
// Multiplexed 8-digit 7-segment scanner: a slot divider steps a 3-bit digit
// index; the selected nibble of the digit register is decoded to segments.
module seg_scan
    import bus_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [31:0] digit_reg,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic [2:0]       idx_q, idx_d;
    logic [3:0]       nibble;

    // Next divider/index: divider wraps at terminal count and bumps the index.
    always_comb begin
        div_d = div_q + 1'b1;
        idx_d = idx_q;
        if (div_q == DIV_LAST) begin
            div_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    // Divider and digit index registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            div_q <= '0;
            idx_q <= '0;
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
        end
    end

    // Digit select and segment decode follow the index and digit register directly.
    always_comb begin
        nibble = digit_reg[{idx_q, 2'b00} +: 4];
        dig_en = ~(8'b1 << idx_q);
        seg    = hex_to_seg(nibble);
    end

endmodule

// File: rtl/bus_bridge.sv
// CPU bus bridge: splits single-cycle CPU transfers between the data RAM and
// a small peripheral page (LED, switches, buttons, timer, 7-segment digits).
module bus_bridge
    import bus_bridge_pkg::*;
#(
    parameter int unsigned SCAN_DIV = SCAN_DIV_DEFAULT
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic [1:0]  en_data_trans,
    input  logic [31:0] addr_in,
    input  logic [31:0] Bus_wdata,
    output logic [31:0] data_to_cpu,
    output logic [13:0] dram_addr,
    output logic [31:0] dram_wdata,
    output logic        dram_we,
    input  logic [31:0] dram_rdata,
    input  logic [23:0] sw,
    input  logic [4:0]  button,
    output logic [23:0] led,
    output logic [7:0]  dig_en,
    output logic [7:0]  seg
);

    logic        periph_sel;
    logic        is_read;
    logic        is_write;
    logic        wr_led, wr_dig, wr_timer;

    logic [23:0] led_q, led_d;
    logic [31:0] dig_q, dig_d;
    logic [31:0] timer_q, timer_d;

    // Address decode and transfer qualification; writes are blocked during reset.
    always_comb begin
        periph_sel = (addr_in[31:12] == PERIPH_PAGE);
        is_read    = (en_data_trans == TRANS_READ);
        is_write   = (en_data_trans == TRANS_WRITE) && !cpu_rst;
        wr_led     = is_write && (addr_in == ADDR_LED);
        wr_dig     = is_write && (addr_in == ADDR_DIG);
        wr_timer   = is_write && (addr_in == ADDR_TIMER);
        dram_we    = is_write && !periph_sel;
        dram_addr  = addr_in[15:2];
        dram_wdata = Bus_wdata;
    end

    // Next-state for peripheral registers; a timer write overrides the increment.
    always_comb begin
        led_d   = led_q;
        dig_d   = dig_q;
        timer_d = timer_q + 32'd1;
        if (wr_led)   led_d   = Bus_wdata[23:0];
        if (wr_dig)   dig_d   = Bus_wdata;
        if (wr_timer) timer_d = Bus_wdata;
    end

    // Peripheral registers.
    always_ff @(posedge cpu_clk or posedge cpu_rst) begin
        if (cpu_rst) begin
            led_q   <= '0;
            dig_q   <= '0;
            timer_q <= '0;
        end else begin
            led_q   <= led_d;
            dig_q   <= dig_d;
            timer_q <= timer_d;
        end
    end

    // Zero-latency read mux; the timer read shows the count held before any same-cycle write.
    always_comb begin
        data_to_cpu = '0;
        if (is_read) begin
            if (!periph_sel) begin
                data_to_cpu = dram_rdata;
            end else begin
                case (addr_in)
                    ADDR_SW:    data_to_cpu = {8'h0, sw};
                    ADDR_BTN:   data_to_cpu = {27'h0, button};
                    ADDR_TIMER: data_to_cpu = timer_q;
                    ADDR_DIG:   data_to_cpu = dig_q;
                    default:    data_to_cpu = '0;
                endcase
            end
        end
    end

    assign led = led_q;

    seg_scan #(
        .SCAN_DIV (SCAN_DIV)
    ) u_seg_scan (
        .cpu_clk   (cpu_clk),
        .cpu_rst   (cpu_rst),
        .digit_reg (dig_q),
        .dig_en    (dig_en),
        .seg       (seg)
    );

endmodule

// File: tb/tb_bus_bridge.sv
// Directed self-checking bench for bus_bridge with a fast scan rate.
module tb_bus_bridge;

    logic        cpu_clk;
    logic        cpu_rst;
    logic [1:0]  en_data_trans;
    logic [31:0] addr_in;
    logic [31:0] Bus_wdata;
    logic [31:0] data_to_cpu;
    logic [13:0] dram_addr;
    logic [31:0] dram_wdata;
    logic        dram_we;
    logic [31:0] dram_rdata;
    logic [23:0] sw;
    logic [4:0]  button;
    logic [23:0] led;
    logic [7:0]  dig_en;
    logic [7:0]  seg;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] mem [0:16383];

    bus_bridge #(
        .SCAN_DIV (4)
    ) dut (
        .cpu_clk       (cpu_clk),
        .cpu_rst       (cpu_rst),
        .en_data_trans (en_data_trans),
        .addr_in       (addr_in),
        .Bus_wdata     (Bus_wdata),
        .data_to_cpu   (data_to_cpu),
        .dram_addr     (dram_addr),
        .dram_wdata    (dram_wdata),
        .dram_we       (dram_we),
        .dram_rdata    (dram_rdata),
        .sw            (sw),
        .button        (button),
        .led           (led),
        .dig_en        (dig_en),
        .seg           (seg)
    );

    initial begin
        cpu_clk = 1'b0;
        forever #5 cpu_clk = ~cpu_clk;
    end

    // Data RAM: synchronous write, asynchronous read.
    always @(posedge cpu_clk) begin
        if (dram_we) mem[dram_addr] <= dram_wdata;
    end
    assign dram_rdata = mem[dram_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge cpu_clk);
        #1;
    endtask

    task automatic bus(input logic [1:0] en, input logic [31:0] addr, input logic [31:0] wd);
        en_data_trans = en;
        addr_in       = addr;
        Bus_wdata     = wd;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = '0;
        cpu_rst       = 1'b1;
        en_data_trans = 2'b00;
        addr_in       = 32'hFFFF_FFFF;
        Bus_wdata     = '0;
        sw            = 24'h123456;
        button        = 5'h15;
        tick(3);

        // Reset state
        check_eq("rst_led", {8'h0, led}, 32'h0);
        check_eq("rst_dig_en", {24'h0, dig_en}, 32'hFE);
        check_eq("rst_seg", {24'h0, seg}, 32'hC0);
        bus(2'b01, 32'hFFFF_F020, 32'h0);
        check_eq("rst_timer_rd", data_to_cpu, 32'h0);
        bus(2'b01, 32'hFFFF_F000, 32'h0);
        check_eq("rst_dig_rd", data_to_cpu, 32'h0);
        bus(2'b10, 32'h0000_0104, 32'h1234_5678);
        check_eq("rst_dram_we", {31'h0, dram_we}, 32'h0);
        bus(2'b00, 32'hFFFF_FFFF, 32'h0);
        tick();
        cpu_rst = 1'b0;

        // DRAM write then read
        bus(2'b10, 32'h0000_0104, 32'hDEAD_BEEF);
        check_eq("dram_we", {31'h0, dram_we}, 32'h1);
        check_eq("dram_addr", {18'h0, dram_addr}, 32'h041);
        check_eq("dram_wdata", dram_wdata, 32'hDEAD_BEEF);
        check_eq("wr_rdata_zero", data_to_cpu, 32'h0);
        tick();
        bus(2'b01, 32'h0000_0104, 32'h0);
        check_eq("dram_rd", data_to_cpu, 32'hDEAD_BEEF);
        check_eq("dram_rd_we", {31'h0, dram_we}, 32'h0);

        // Read-only and unmapped peripheral reads
        bus(2'b01, 32'hFFFF_F070, 32'h0);
        check_eq("sw_rd", data_to_cpu, 32'h0012_3456);
        bus(2'b01, 32'hFFFF_F078, 32'h0);
        check_eq("btn_rd", data_to_cpu, 32'h0000_0015);
        bus(2'b01, 32'hFFFF_F0F0, 32'h0);
        check_eq("unmapped_rd", data_to_cpu, 32'h0);
        bus(2'b01, 32'hFFFF_FFFF, 32'h0);
        check_eq("fff_rd", data_to_cpu, 32'h0);

        // LED write, then writes that must not touch it
        bus(2'b10, 32'hFFFF_F060, 32'h77A5_A5A5);
        check_eq("led_wr_we", {31'h0, dram_we}, 32'h0);
        tick();
        check_eq("led_val", {8'h0, led}, 32'h00A5_A5A5);
        bus(2'b01, 32'hFFFF_F060, 32'h0);
        check_eq("led_rd_zero", data_to_cpu, 32'h0);
        bus(2'b10, 32'hFFFF_F0F0, 32'h0012_3456);
        check_eq("unmapped_wr_we", {31'h0, dram_we}, 32'h0);
        tick();
        check_eq("led_after_unmapped", {8'h0, led}, 32'h00A5_A5A5);
        bus(2'b10, 32'hFFFF_F070, 32'h0000_0000);
        tick();
        check_eq("led_after_sw_wr", {8'h0, led}, 32'h00A5_A5A5);

        // Idle and reserved codes
        bus(2'b00, 32'hFFFF_FFFF, 32'h0);
        check_eq("idle_rd", data_to_cpu, 32'h0);
        check_eq("idle_we", {31'h0, dram_we}, 32'h0);
        bus(2'b11, 32'h0000_0104, 32'h0);
        check_eq("rsvd_rd", data_to_cpu, 32'h0);
        check_eq("rsvd_we", {31'h0, dram_we}, 32'h0);
        bus(2'b11, 32'hFFFF_F060, 32'h0);
        tick();
        check_eq("rsvd_led", {8'h0, led}, 32'h00A5_A5A5);

        // Timer load, count, same-cycle read, wrap
        bus(2'b10, 32'hFFFF_F020, 32'd100);
        tick();
        bus(2'b01, 32'hFFFF_F020, 32'h0);
        check_eq("tmr_load", data_to_cpu, 32'd100);
        tick();
        check_eq("tmr_inc", data_to_cpu, 32'd101);
        bus(2'b10, 32'hFFFF_F020, 32'hFFFF_FFFE);
        @(negedge cpu_clk);
        en_data_trans = 2'b01;
        #1;
        check_eq("tmr_same_cycle", data_to_cpu, 32'd101);
        en_data_trans = 2'b10;
        tick();
        bus(2'b01, 32'hFFFF_F020, 32'h0);
        check_eq("tmr_fffe", data_to_cpu, 32'hFFFF_FFFE);
        tick();
        check_eq("tmr_ffff", data_to_cpu, 32'hFFFF_FFFF);
        tick();
        check_eq("tmr_wrap0", data_to_cpu, 32'h0);
        tick();
        check_eq("tmr_wrap1", data_to_cpu, 32'h1);

        // Digit scan from a fresh reset
        bus(2'b00, 32'hFFFF_FFFF, 32'h0);
        cpu_rst = 1'b1;
        #1;
        check_eq("rst2_led", {8'h0, led}, 32'h0);
        tick();
        cpu_rst = 1'b0;
        bus(2'b10, 32'hFFFF_F000, 32'h7654_3210);
        tick();
        bus(2'b01, 32'hFFFF_F000, 32'h0);
        check_eq("dig_rd", data_to_cpu, 32'h7654_3210);
        check_eq("scan0_en", {24'h0, dig_en}, 32'hFE);
        check_eq("scan0_seg", {24'h0, seg}, 32'hC0);
        tick(2);
        check_eq("scan0_hold", {24'h0, dig_en}, 32'hFE);
        tick();
        check_eq("scan1_en", {24'h0, dig_en}, 32'hFD);
        check_eq("scan1_seg", {24'h0, seg}, 32'hF9);
        tick(8);
        check_eq("scan3_en", {24'h0, dig_en}, 32'hF7);
        check_eq("scan3_seg", {24'h0, seg}, 32'hB0);
        tick(16);
        check_eq("scan7_en", {24'h0, dig_en}, 32'h7F);
        check_eq("scan7_seg", {24'h0, seg}, 32'hF8);
        tick(4);
        check_eq("scanwrap_en", {24'h0, dig_en}, 32'hFE);
        check_eq("scanwrap_seg", {24'h0, seg}, 32'hC0);
        bus(2'b10, 32'hFFFF_F000, 32'h89AB_CDEF);
        tick();
        bus(2'b00, 32'hFFFF_FFFF, 32'h0);
        check_eq("digwr_en", {24'h0, dig_en}, 32'hFE);
        check_eq("digwr_seg", {24'h0, seg}, 32'h8E);
        tick(3);
        check_eq("digwr_next_en", {24'h0, dig_en}, 32'hFD);
        check_eq("digwr_next_seg", {24'h0, seg}, 32'h86);

        // Reset in the middle of an LED write
        bus(2'b10, 32'hFFFF_F060, 32'h0012_3456);
        tick();
        check_eq("led_pre_rst", {8'h0, led}, 32'h0012_3456);
        bus(2'b10, 32'hFFFF_F060, 32'h0065_4321);
        #2;
        cpu_rst = 1'b1;
        #1;
        check_eq("midrst_led", {8'h0, led}, 32'h0);
        check_eq("midrst_dig_en", {24'h0, dig_en}, 32'hFE);
        check_eq("midrst_seg", {24'h0, seg}, 32'hC0);
        tick();
        bus(2'b10, 32'h0000_0200, 32'h1111_1111);
        check_eq("midrst_dram_we", {31'h0, dram_we}, 32'h0);
        tick();
        bus(2'b00, 32'hFFFF_FFFF, 32'h0);
        cpu_rst = 1'b0;
        tick();
        check_eq("post_rst_led", {8'h0, led}, 32'h0);
        bus(2'b01, 32'h0000_0200, 32'h0);
        check_eq("post_rst_dram", data_to_cpu, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
